lcd1602_writer: RTL

- Consumer end of the 2x16 display interface that game logic drives with 128-bit top/bottom ASCII rows (16 chars each, column 0 in bits [127:120]).
- Runs HD44780 8-bit power-up/init, then repeatedly snapshots both rows and streams them to the LCD with correctly timed RS/EN/data.
- Sits between host/player display logic and the board LCD pins.

---
 rtl/lcd1602_writer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_writer.sv
// HD44780 8-bit writer for a 2x16 LCD: power-up wait, init sequence, then framed row refresh.
// Optional LCD_CHANGE_ONLY_EN: skip rewriting a frame identical to the last completed one.
module lcd1602_writer #(
    parameter logic [15:0] PWRUP_CYC = 16'd40000,
    parameter logic [15:0] CMD_CYC   = 16'd400,
    parameter logic [15:0] CLR_CYC   = 16'd16000,
    parameter logic [3:0]  SETUP_CYC = 4'd2,
    parameter logic [3:0]  EN_CYC    = 4'd4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] top,
    input  logic [127:0] bottom,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned ROW_W = 128;
    localparam int unsigned COL_W = 4;
    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] INIT_LAST = 3'd5;
    localparam logic [IDX_W-1:0] INIT_CLR  = 3'd4;
    localparam logic [COL_W-1:0] COL_LAST  = 4'd15;

    // Last count value of each dwell; a zero parameter still dwells one cycle.
    localparam logic [CNT_W-1:0] PWRUP_LAST = (PWRUP_CYC == 16'd0) ? 16'd0 : PWRUP_CYC - 16'd1;
    localparam logic [CNT_W-1:0] CMD_LAST   = (CMD_CYC == 16'd0)   ? 16'd0 : CMD_CYC - 16'd1;
    localparam logic [CNT_W-1:0] CLR_LAST   = (CLR_CYC == 16'd0)   ? 16'd0 : CLR_CYC - 16'd1;
    localparam logic [CNT_W-1:0] SETUP_LAST = (SETUP_CYC == 4'd0)  ? 16'd0 : 16'(SETUP_CYC) - 16'd1;
    localparam logic [CNT_W-1:0] EN_LAST    = (EN_CYC == 4'd0)     ? 16'd0 : 16'(EN_CYC) - 16'd1;

    // Init bytes reuse SETUP/PULSE/WAIT; in_init marks that phase.
    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_FRAME = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_IDLE  = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               in_init;
    logic [IDX_W-1:0]   init_idx;
    logic               row;
    logic [COL_W-1:0]   col;
    logic               addr_item;
    logic [ROW_W-1:0]   shadow_top;
    logic [ROW_W-1:0]   shadow_bot;
`ifdef LCD_CHANGE_ONLY_EN
    logic [2*ROW_W-1:0] last_frame;
    logic               last_valid;
`endif

    logic [CNT_W-1:0]   cur_last_c;
    logic               dwell_done_c;
    logic [COL_W-1:0]   col_sel_c;
    logic [ROW_W-1:0]   shifted_c;
    logic [7:0]         char_c;

    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    // Unprintable bytes (including upstream zero padding) show as blanks.
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        sanitize = ((b < 8'h20) || (b > 8'h7E)) ? 8'h20 : b;
    endfunction

    always_comb begin
        cur_last_c = 16'd0;
        case (state)
            ST_PWRUP: cur_last_c = PWRUP_LAST;
            ST_SETUP: cur_last_c = SETUP_LAST;
            ST_PULSE: cur_last_c = EN_LAST;
            ST_WAIT:  cur_last_c = (in_init && (init_idx == INIT_CLR)) ? CLR_LAST : CMD_LAST;
            default:  cur_last_c = 16'd0;
        endcase
        dwell_done_c = (cnt >= cur_last_c);
    end

    // Character for the next data item: column 0 after an address command, else col+1.
    always_comb begin
        col_sel_c = addr_item ? 4'd0 : col + 4'd1;
        shifted_c = (row ? shadow_bot : shadow_top) << {col_sel_c, 3'b000};
        char_c    = sanitize(shifted_c[ROW_W-1 -: 8]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_PWRUP;
            cnt        <= '0;
            in_init    <= 1'b0;
            init_idx   <= '0;
            row        <= 1'b0;
            col        <= '0;
            addr_item  <= 1'b0;
            shadow_top <= '0;
            shadow_bot <= '0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_en     <= 1'b0;
            busy       <= 1'b1;
            frame_done <= 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
            last_frame <= '0;
            last_valid <= 1'b0;
`endif
        end else begin
            cnt        <= cnt + 16'd1;
            frame_done <= 1'b0;
            lcd_rw     <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    if (dwell_done_c) begin
                        in_init  <= 1'b1;
                        init_idx <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(3'd0);
                        state    <= ST_SETUP;
                        cnt      <= '0;
                    end
                end

                ST_SETUP: begin
                    if (dwell_done_c) begin
                        lcd_en <= 1'b1;
                        state  <= ST_PULSE;
                        cnt    <= '0;
                    end
                end

                ST_PULSE: begin
                    if (dwell_done_c) begin
                        lcd_en <= 1'b0;
                        state  <= ST_WAIT;
                        cnt    <= '0;
                    end
                end

                ST_WAIT: begin
                    if (dwell_done_c) begin
                        cnt <= '0;
                        if (in_init) begin
                            if (init_idx == INIT_LAST) begin
                                in_init <= 1'b0;
                                state   <= ST_FRAME;
                            end else begin
                                init_idx <= init_idx + 3'd1;
                                lcd_rs   <= 1'b0;
                                lcd_data <= init_byte(init_idx + 3'd1);
                                state    <= ST_SETUP;
                            end
                        end else if (addr_item) begin
                            addr_item <= 1'b0;
                            lcd_rs    <= 1'b1;
                            lcd_data  <= char_c;
                            state     <= ST_SETUP;
                        end else if (col == COL_LAST) begin
                            if (row) begin
                                frame_done <= 1'b1;
                                state      <= ST_FRAME;
`ifdef LCD_CHANGE_ONLY_EN
                                last_frame <= {shadow_top, shadow_bot};
                                last_valid <= 1'b1;
`endif
                            end else begin
                                row       <= 1'b1;
                                col       <= '0;
                                addr_item <= 1'b1;
                                lcd_rs    <= 1'b0;
                                lcd_data  <= 8'hC0;
                                state     <= ST_SETUP;
                            end
                        end else begin
                            col      <= col + 4'd1;
                            lcd_rs   <= 1'b1;
                            lcd_data <= char_c;
                            state    <= ST_SETUP;
                        end
                    end
                end

                // One-cycle snapshot: the frame is written only from the shadows.
                ST_FRAME: begin
                    cnt <= '0;
`ifdef LCD_CHANGE_ONLY_EN
                    if (last_valid && ({top, bottom} == last_frame)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else
`endif
                    begin
                        shadow_top <= top;
                        shadow_bot <= bottom;
                        row        <= 1'b0;
                        col        <= '0;
                        addr_item  <= 1'b1;
                        lcd_rs     <= 1'b0;
                        lcd_data   <= 8'h80;
                        busy       <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end

                ST_IDLE: begin
                    cnt <= '0;
`ifdef LCD_CHANGE_ONLY_EN
                    if ({top, bottom} != last_frame) begin
                        busy  <= 1'b1;
                        state <= ST_FRAME;
                    end
`else
                    busy  <= 1'b1;
                    state <= ST_FRAME;
`endif
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule
